// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Defaults mirror the core's register address/data widths.
package wb_port_arbiter_pkg;

  localparam int WB_NREQ         = 3;
  localparam int WB_STARVE_LIMIT = 4;
  localparam int REG_ADDR_W      = 5;
  localparam int REG_DATA_W      = 32;

  // Width of the round-robin pointer, which holds a port index 1..nreq-1.
  function automatic int rr_ptr_width(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin search over write-back ports 1..NREQ-1 starting at rr_ptr.
// Bit 0 of grant is never set; port 0 is handled by the arbiter itself.
module wb_rr_picker
  import wb_port_arbiter_pkg::*;
#(
  parameter int NREQ  = WB_NREQ,
  parameter int PTR_W = rr_ptr_width(NREQ)
) (
  input  logic [PTR_W-1:0] rr_ptr,
  input  logic [NREQ-1:0]  valid,
  output logic [NREQ-1:0]  grant,
  output logic             any_valid
);

  logic [NREQ-1:0] low_valid_s;
  logic [NREQ-1:0] hi_valid_s;
  logic [NREQ-1:0] cand_s;

  assign low_valid_s = valid & {{(NREQ-1){1'b1}}, 1'b0};
  assign any_valid   = |low_valid_s;

  // Prefer ports at or above rr_ptr, else wrap to the lowest valid port.
  always_comb begin
    hi_valid_s = '0;
    for (int i = 1; i < NREQ; i++) begin
      hi_valid_s[i] = low_valid_s[i] && (i >= int'(rr_ptr));
    end
    if (|hi_valid_s) begin
      cand_s = hi_valid_s;
    end else begin
      cand_s = low_valid_s;
    end
    grant = cand_s & (~cand_s + {{(NREQ-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between the pipeline WB stage (port 0)
// and long-latency units, with a one-cycle registered write stage.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NREQ         = WB_NREQ,
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int DATA_W       = REG_DATA_W,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_waddr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic                   stall_o,
  output logic                   we_o,
  output logic [ADDR_W-1:0]      waddr_o,
  output logic [DATA_W-1:0]      wdata_o
);

  localparam int               PTR_W     = rr_ptr_width(NREQ);
  localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(1);
  localparam logic [3:0]       LIMIT     = 4'(STARVE_LIMIT);

  logic [PTR_W-1:0]  rr_ptr_r;
  logic [PTR_W-1:0]  rr_ptr_nxt_s;
  logic [3:0]        starve_cnt_r;
  logic [NREQ-1:0]   rr_grant_s;
  logic [NREQ-1:0]   grant_s;
  logic              any_low_s;
  logic              forced_s;
  logic              stall_s;
  logic              xfer_s;
  logic              low_grant_s;
  logic [ADDR_W-1:0] sel_waddr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;

  wb_rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
    .rr_ptr    (rr_ptr_r),
    .valid     (req_valid),
    .grant     (rr_grant_s),
    .any_valid (any_low_s)
  );

  assign forced_s = (starve_cnt_r == LIMIT) && any_low_s;

  // Grant selection: forced low-port grant beats the pipeline, which beats round-robin.
  always_comb begin
    grant_s = '0;
    stall_s = 1'b0;
    if (rst) begin
      grant_s = '0;
    end else if (forced_s) begin
      grant_s = rr_grant_s;
      stall_s = 1'b1;
    end else if (req_valid[0]) begin
      grant_s = {{(NREQ-1){1'b0}}, 1'b1};
    end else begin
      grant_s = rr_grant_s;
    end
  end

  assign req_ready   = grant_s;
  assign stall_o     = stall_s;
  assign xfer_s      = |grant_s;
  assign low_grant_s = |grant_s[NREQ-1:1];

  // One-hot mux of the granted port's address/data and next round-robin pointer.
  always_comb begin
    sel_waddr_s  = '0;
    sel_wdata_s  = '0;
    rr_ptr_nxt_s = rr_ptr_r;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        sel_waddr_s = sel_waddr_s | req_waddr[i*ADDR_W +: ADDR_W];
        sel_wdata_s = sel_wdata_s | req_wdata[i*DATA_W +: DATA_W];
        if (i == 0) begin
          rr_ptr_nxt_s = rr_ptr_r;
        end else if (i == NREQ-1) begin
          rr_ptr_nxt_s = PTR_FIRST;
        end else begin
          rr_ptr_nxt_s = PTR_W'(i + 1);
        end
      end else begin
        sel_waddr_s = sel_waddr_s;
      end
    end
  end

  // Output write stage, round-robin pointer and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r         <= 1'b0;
      waddr_r      <= '0;
      wdata_r      <= '0;
      rr_ptr_r     <= PTR_FIRST;
      starve_cnt_r <= 4'd0;
    end else begin
      // r0 writes are consumed but never reach the register file.
      we_r     <= xfer_s && (sel_waddr_s != '0);
      rr_ptr_r <= rr_ptr_nxt_s;
      if (xfer_s) begin
        waddr_r <= sel_waddr_s;
        wdata_r <= sel_wdata_s;
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
      end
      if (low_grant_s) begin
        starve_cnt_r <= 4'd0;
      end else if (any_low_s && (starve_cnt_r != LIMIT)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  assign we_o    = we_r;
  assign waddr_o = waddr_r;
  assign wdata_o = wdata_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter (NREQ=3, STARVE_LIMIT=4).
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_waddr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic                 stall_o;
  logic                 we_o;
  logic [AW-1:0]        waddr_o;
  logic [DW-1:0]        wdata_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;

  wb_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .stall_o   (stall_o),
    .we_o      (we_o),
    .waddr_o   (waddr_o),
    .wdata_o   (wdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] v);
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_waddr[i*AW +: AW] = a[i];
      req_wdata[i*DW +: DW] = d[i];
    end
  endtask

  // Apply one request vector at a falling edge, check the grant, then the write stage.
  task automatic cycle(input string tag, input logic [NREQ-1:0] v,
                       input logic [NREQ-1:0] exp_rdy, input logic exp_stall);
    int   k;
    logic exp_we;
    drive(v);
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    check({tag, "_stall"}, 64'(stall_o), 64'(exp_stall));
    k = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i]) k = i;
    end
    @(negedge clk);
    exp_we = 1'b0;
    if (k >= 0) begin
      exp_we = (a[k] != '0);
      if (exp_we) begin
        exp_waddr = a[k];
        exp_wdata = d[k];
      end
      d[k] = d[k] + 32'h1;
    end
    check({tag, "_we"}, 64'(we_o), 64'(exp_we));
    if (exp_we) begin
      check({tag, "_waddr"}, 64'(waddr_o), 64'(exp_waddr));
      check({tag, "_wdata"}, 64'(wdata_o), 64'(exp_wdata));
    end
  endtask

  // Requester protocol: a pending request keeps valid, address and data stable.
  logic [NREQ-1:0]    pend_r = '0;
  logic [NREQ*AW-1:0] pa_r;
  logic [NREQ*DW-1:0] pd_r;
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (pend_r[i]) begin
        assert (req_valid[i] && req_waddr[i*AW +: AW] == pa_r[i*AW +: AW]
                && req_wdata[i*DW +: DW] == pd_r[i*DW +: DW])
          else $error("FAIL protocol port %0d changed while pending", i);
      end
    end
    pend_r <= req_valid & ~req_ready;
    pa_r   <= req_waddr;
    pd_r   <= req_wdata;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    a[0] = 5'd3; d[0] = 32'hDEADBEEF;
    a[1] = 5'd5; d[1] = 32'h1111_0001;
    a[2] = 5'd7; d[2] = 32'h2222_0001;
    exp_waddr = '0;
    exp_wdata = '0;

    rst = 1'b1;
    drive(3'b111);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_we", 64'(we_o), 64'd0);
    check("rst_waddr", 64'(waddr_o), 64'd0);
    check("rst_wdata", 64'(wdata_o), 64'd0);
    @(negedge clk);

    rst = 1'b0;
    cycle("p0_first", 3'b111, 3'b001, 1'b0);
    cycle("rr1", 3'b110, 3'b010, 1'b0);
    cycle("rr2", 3'b110, 3'b100, 1'b0);
    cycle("rr3", 3'b110, 3'b010, 1'b0);
    cycle("rr4", 3'b110, 3'b100, 1'b0);
    cycle("rr5", 3'b010, 3'b010, 1'b0);
    cycle("idle", 3'b000, 3'b000, 1'b0);
    check("idle_hold_waddr", 64'(waddr_o), 64'(exp_waddr));
    check("idle_hold_wdata", 64'(wdata_o), 64'(exp_wdata));

    for (int i = 0; i < 4; i++) begin
      cycle("starve_wait", 3'b011, 3'b001, 1'b0);
    end
    cycle("starve_force", 3'b011, 3'b010, 1'b1);
    cycle("after_force", 3'b001, 3'b001, 1'b0);

    a[2] = 5'd0; d[2] = 32'h0000_1234;
    cycle("r0_drop", 3'b100, 3'b100, 1'b0);
    a[2] = 5'd9;
    cycle("r0_ptr", 3'b110, 3'b010, 1'b0);
    cycle("r0_ptr2", 3'b100, 3'b100, 1'b0);

    cycle("mid_p1", 3'b010, 3'b010, 1'b0);
    rst = 1'b1;
    drive(3'b010);
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    check("mid_rst_we", 64'(we_o), 64'd0);
    check("mid_rst_waddr", 64'(waddr_o), 64'd0);
    check("mid_rst_wdata", 64'(wdata_o), 64'd0);
    rst = 1'b0;
    cycle("post_rst", 3'b010, 3'b010, 1'b0);
    cycle("end_idle", 3'b000, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between NREQ write-back sources.
- Port 0 is the in-order pipeline WB stage. Ports 1..NREQ-1 are long-latency units (divider, multiplier, late load return).
- Arbitrates each cycle and registers the winning write into a one-cycle output stage that drives the register file's we/waddr/wdata.
- Anti-starvation logic stalls the pipeline when a slow unit has waited too long.

Parameters:
- NREQ, 3, number of requesters (2..8); port 0 is always the pipeline.
- ADDR_W, 5, register address width (`RegNumLog2).
- DATA_W, 32, write data width (`RegBus).
- STARVE_LIMIT, 4, consecutive losing cycles of a valid low-priority port before a forced grant (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-port write request.
- req_ready  out  NREQ  per-port grant; transfer when valid&ready.
- req_waddr  in  NREQ*ADDR_W  per-port destination, port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  per-port data, port i at [i*DATA_W +: DATA_W].
- stall_o  out  1  to pipeline control: port 0 is blocked this cycle by a forced grant.
- we_o  out  1  register file write enable.
- waddr_o  out  ADDR_W  register file write address.
- wdata_o  out  DATA_W  register file write data.

Behaviour:
- Reset (synchronous, rst=1): we_o=0, waddr_o=0, wdata_o=0, rr_ptr=1, starve_cnt=0. req_ready=0 and stall_o=0 while rst=1.
- Grant rules (combinational, cycle t, at most one bit of req_ready set):
  - Forced case: starve_cnt==STARVE_LIMIT and any of ports 1..NREQ-1 valid. Grant the round-robin winner among ports 1..NREQ-1, hold req_ready[0]=0, and set stall_o=1.
  - Otherwise, if req_valid[0]=1, grant port 0.
  - Otherwise, grant the round-robin winner among the valid ports 1..NREQ-1, searching upward from rr_ptr and wrapping NREQ-1 -> 1.
  - No valid port: no grant.
- stall_o=1 only in the forced case, and only in the same cycle.
- Latency: a transfer at edge t produces we_o/waddr_o/wdata_o valid during cycle t+1, so the write lands in the register file at edge t+2.
  - Throughput is one write per cycle.
  - Output stage loads every cycle. With no transfer, we_o=0 and waddr_o/wdata_o hold their last values.
- r0 handling: a transfer with waddr==0 is accepted (ready given, counts as a grant for rr_ptr and starve_cnt) but gives we_o=0 next cycle.
- rr_ptr: after a grant to port k>=1, rr_ptr = k+1, wrapping to 1 after NREQ-1. It is unchanged on a port 0 grant or when idle.
- starve_cnt:
  - Clears on any grant to ports 1..NREQ-1.
  - Otherwise increments, saturating at STARVE_LIMIT, when any of ports 1..NREQ-1 is valid and not granted.
  - Holds when no low port is valid.
- Requester protocol: once req_valid[i] is raised, valid, waddr and wdata stay stable until the transfer. The arbiter does not check this; the bench asserts it.
- Ordering:
  - Same-address writes from different ports commit in grant order, and the last one wins.
  - The arbiter does no WAW hazard detection; pipeline control is responsible.
- Reset mid-operation: the output stage is cleared, so a write pending in the output stage is lost. Requests still valid on the cycle rst falls are arbitrated normally from reset state.
- NREQ=2: the round-robin pointer is constant 1.

Decomposition:
- Shared defines file: WB_NREQ default, WB_STARVE_LIMIT, reuse of `RegAddrBus/`RegBus/`WriteEnable/`ZeroWord.
- Sub-module wb_rr_picker: combinational round-robin search over ports 1..NREQ-1 given rr_ptr and the valid mask; outputs a one-hot grant and an any-valid flag.

Test Plan:
- Reset: rst=1 with all ports valid -> req_ready=0, we_o=0, waddr_o=0, wdata_o=0, stall_o=0. Release rst -> port 0 granted first cycle.
- Port 0 only: waddr=3, wdata=0xDEADBEEF at edge t -> we_o=1, waddr_o=3, wdata_o=0xDEADBEEF in cycle t+1.
- Round-robin: port 0 idle, ports 1 and 2 valid continuously with distinct data -> grants alternate 1,2,1,2 and outputs follow one cycle later.
- Starvation: port 0 valid every cycle, port 1 valid from cycle 0 -> port 0 granted 4 cycles, then on cycle 4 port 1 granted with stall_o=1 and req_ready[0]=0; starve_cnt resets.
- r0 drop: port 2 writes waddr=0, wdata=0x1234 -> req_ready[2]=1, next cycle we_o=0, and rr_ptr still advances to 1.
- Reset mid-stream: grant port 1 at edge t, assert rst in cycle t+1 -> we_o=0 at edge t+1, and no write reaches the register file.
